// File: rtl/csr_pkg.sv
// Shared CSR definitions: addresses, mstatus field positions, trap causes,
// the trap sequencer state type and the mstatus update rules.
package csr_pkg;

  localparam int CSR_XLEN = 32;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;

  localparam int MS_MIE    = 3;
  localparam int MS_MPIE   = 7;
  localparam int MS_MPP_LO = 11;
  localparam int MS_MPP_HI = 12;

  localparam logic [CSR_XLEN-1:0] CAUSE_ECALL_M      = 32'd11;
  localparam logic [CSR_XLEN-1:0] CAUSE_ILLEGAL_INSN = 32'd2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_T_EPC  = 3'd1,
    S_T_CAUSE = 3'd2,
    S_T_STAT = 3'd3,
    S_T_VEC  = 3'd4,
    S_R_STAT = 3'd5,
    S_R_EPC  = 3'd6
  } state_e;

  // Trap entry: stash MIE in MPIE, disable interrupts, record M-mode as previous.
  function automatic logic [CSR_XLEN-1:0] mstatus_on_trap(input logic [CSR_XLEN-1:0] s);
    logic [CSR_XLEN-1:0] r;
    r = s;
    r[MS_MPIE] = s[MS_MIE];
    r[MS_MIE] = 1'b0;
    r[MS_MPP_HI:MS_MPP_LO] = 2'b11;
    return r;
  endfunction

  // Trap return: restore MIE from MPIE, re-arm MPIE, stay in M-mode.
  function automatic logic [CSR_XLEN-1:0] mstatus_on_mret(input logic [CSR_XLEN-1:0] s);
    logic [CSR_XLEN-1:0] r;
    r = s;
    r[MS_MIE] = s[MS_MPIE];
    r[MS_MPIE] = 1'b1;
    r[MS_MPP_HI:MS_MPP_LO] = 2'b11;
    return r;
  endfunction

endpackage

// File: rtl/csr_trap_ctrl.sv
// Trap entry / mret sequencer owning the CSR write port and read address,
// with pass-through of EXU CSR instructions while idle.
module csr_trap_ctrl
  import csr_pkg::*;
#(
  parameter int          XLEN      = CSR_XLEN,
  parameter logic [11:0] A_MSTATUS = CSR_MSTATUS,
  parameter logic [11:0] A_MTVEC   = CSR_MTVEC,
  parameter logic [11:0] A_MEPC    = CSR_MEPC,
  parameter logic [11:0] A_MCAUSE  = CSR_MCAUSE
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_mret,
  input  logic [XLEN-1:0] req_pc,
  input  logic [XLEN-1:0] req_cause,
  input  logic            inst_we,
  input  logic [11:0]     inst_waddr,
  input  logic [XLEN-1:0] inst_wdata,
  input  logic [11:0]     inst_raddr,
  output logic            inst_ready,
  output logic            csr_we,
  output logic [11:0]     csr_waddr,
  output logic [XLEN-1:0] csr_wdata,
  output logic [11:0]     csr_raddr,
  input  logic [XLEN-1:0] csr_rdata,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            busy
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic            accept;

  // Handshakes: a request transfers when req_valid && req_ready; a CSR
  // instruction transfers when inst_ready is high. Neither side is queued,
  // so the producer holds its inputs until the transfer cycle.
  assign req_ready  = (state_q == S_IDLE);
  assign inst_ready = req_ready && !req_valid;
  assign accept     = req_valid && req_ready;
  assign busy       = (state_q != S_IDLE);

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    cause_d        = cause_q;
    csr_we         = 1'b0;
    csr_waddr      = inst_waddr;
    csr_wdata      = inst_wdata;
    csr_raddr      = inst_raddr;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    case (state_q)
      S_IDLE: begin
        if (inst_ready) csr_we = inst_we;
        if (accept) begin
          pc_d    = req_pc;
          cause_d = req_cause;
          state_d = req_mret ? S_R_STAT : S_T_EPC;
        end
      end
      S_T_EPC: begin
        csr_we    = 1'b1;
        csr_waddr = A_MEPC;
        csr_wdata = {pc_q[XLEN-1:2], 2'b00};
        state_d   = S_T_CAUSE;
      end
      S_T_CAUSE: begin
        csr_we    = 1'b1;
        csr_waddr = A_MCAUSE;
        csr_wdata = cause_q;
        state_d   = S_T_STAT;
      end
      S_T_STAT: begin
        csr_raddr = A_MSTATUS;
        csr_we    = 1'b1;
        csr_waddr = A_MSTATUS;
        csr_wdata = mstatus_on_trap(csr_rdata);
        state_d   = S_T_VEC;
      end
      S_T_VEC: begin
        // Only direct mode is supported, so the mode bits are simply cleared.
        csr_raddr      = A_MTVEC;
        redirect_valid = 1'b1;
        redirect_pc    = {csr_rdata[XLEN-1:2], 2'b00};
        state_d        = S_IDLE;
      end
      S_R_STAT: begin
        csr_raddr = A_MSTATUS;
        csr_we    = 1'b1;
        csr_waddr = A_MSTATUS;
        csr_wdata = mstatus_on_mret(csr_rdata);
        state_d   = S_R_EPC;
      end
      S_R_EPC: begin
        csr_raddr      = A_MEPC;
        redirect_valid = 1'b1;
        redirect_pc    = csr_rdata;
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cause_q <= cause_d;
    end
  end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Self-checking bench for csr_trap_ctrl: a CSR-file stand-in, a shadow CSR
// model that predicts every cycle of each sequence, directed and random steps.
module tb_csr_trap_ctrl;
  import csr_pkg::*;

  localparam int XLEN = 32;
  localparam int TW   = 1 + 12 + XLEN + 1 + XLEN;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            req_valid, req_ready, req_mret;
  logic [XLEN-1:0] req_pc, req_cause;
  logic            inst_we, inst_ready;
  logic [11:0]     inst_waddr, inst_raddr;
  logic [XLEN-1:0] inst_wdata;
  logic            csr_we;
  logic [11:0]     csr_waddr, csr_raddr;
  logic [XLEN-1:0] csr_wdata, csr_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [TW-1:0]   exp_q[$];
  logic [XLEN-1:0] m_mstatus, m_mtvec, m_mepc, m_mcause;
  logic [XLEN-1:0] csr_mem [0:4095];

  csr_trap_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_mret(req_mret),
    .req_pc(req_pc), .req_cause(req_cause),
    .inst_we(inst_we), .inst_waddr(inst_waddr), .inst_wdata(inst_wdata),
    .inst_raddr(inst_raddr), .inst_ready(inst_ready),
    .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
  );

  // ---------------- clock / reset / CSR file stand-in ----------------
  always #5 clk = ~clk;

  always @(posedge clk) if (csr_we) csr_mem[csr_waddr] <= csr_wdata;
  assign csr_rdata = csr_mem[csr_raddr];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [XLEN-1:0] ref_trap_ms(input logic [XLEN-1:0] s);
    return (s & ~32'h0000_1888) | 32'h0000_1800 | ((s & 32'h8) << 4);
  endfunction

  function automatic logic [XLEN-1:0] ref_mret_ms(input logic [XLEN-1:0] s);
    return (s & ~32'h0000_1888) | 32'h0000_1880 | ((s >> 4) & 32'h8);
  endfunction

  function automatic logic [XLEN-1:0] ref_read(input logic [11:0] a);
    case (a)
      CSR_MSTATUS: return m_mstatus;
      CSR_MTVEC:   return m_mtvec;
      CSR_MEPC:    return m_mepc;
      CSR_MCAUSE:  return m_mcause;
      default:     return '0;
    endcase
  endfunction

  function automatic logic [TW-1:0] ent(input logic we, input logic [11:0] a,
                                       input logic [XLEN-1:0] d, input logic rv,
                                       input logic [XLEN-1:0] rp);
    return {we, a, d, rv, rp};
  endfunction

  function automatic logic [TW-1:0] obs_trace();
    return {csr_we, csr_we ? csr_waddr : 12'h0, csr_we ? csr_wdata : 32'h0,
            redirect_valid, redirect_valid ? redirect_pc : 32'h0};
  endfunction

  // ---------------- scoreboard check ----------------
  task automatic check(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid  = 1'b0;
    req_mret   = 1'($urandom);
    req_pc     = $urandom;
    req_cause  = $urandom;
    inst_we    = 1'b0;
    inst_waddr = 12'($urandom);
    inst_wdata = $urandom;
    inst_raddr = 12'($urandom);
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [XLEN-1:0] d);
    req_valid  = 1'b0;
    inst_we    = 1'b1;
    inst_waddr = a;
    inst_wdata = d;
    inst_raddr = a;
    @(negedge clk);
    check("wr_pass", {inst_ready, csr_we, csr_waddr, csr_wdata, csr_raddr},
          {1'b1, 1'b1, a, d, a});
    next_cycle();
    inst_we = 1'b0;
    case (a)
      CSR_MSTATUS: m_mstatus = d;
      CSR_MTVEC:   m_mtvec = d;
      CSR_MEPC:    m_mepc = d;
      CSR_MCAUSE:  m_mcause = d;
      default: ;
    endcase
  endtask

  task automatic csr_read_check(input string tag, input logic [11:0] a);
    req_valid  = 1'b0;
    inst_we    = 1'b0;
    inst_raddr = a;
    @(negedge clk);
    check(tag, {inst_ready, csr_we, csr_raddr, csr_rdata}, {1'b1, 1'b0, a, ref_read(a)});
    next_cycle();
  endtask

  // Issues one request; with hold_we an instruction write is presented from the
  // accept cycle on and is left asserted for the caller when this returns.
  task automatic run_req(input logic mret, input logic [XLEN-1:0] pc,
                         input logic [XLEN-1:0] cause, input logic hold_we,
                         input logic [11:0] hold_a, input logic [XLEN-1:0] hold_d);
    logic [XLEN-1:0] ms_new;
    if (!mret) begin
      ms_new = ref_trap_ms(m_mstatus);
      exp_q.push_back(ent(1'b1, CSR_MEPC, pc & ~32'h3, 1'b0, '0));
      exp_q.push_back(ent(1'b1, CSR_MCAUSE, cause, 1'b0, '0));
      exp_q.push_back(ent(1'b1, CSR_MSTATUS, ms_new, 1'b0, '0));
      exp_q.push_back(ent(1'b0, 12'h0, '0, 1'b1, m_mtvec & ~32'h3));
      m_mepc = pc & ~32'h3;
      m_mcause = cause;
    end else begin
      ms_new = ref_mret_ms(m_mstatus);
      exp_q.push_back(ent(1'b1, CSR_MSTATUS, ms_new, 1'b0, '0));
      exp_q.push_back(ent(1'b0, 12'h0, '0, 1'b1, m_mepc));
    end
    m_mstatus = ms_new;

    req_valid  = 1'b1;
    req_mret   = mret;
    req_pc     = pc;
    req_cause  = cause;
    inst_we    = hold_we;
    inst_waddr = hold_we ? hold_a : 12'($urandom);
    inst_wdata = hold_we ? hold_d : $urandom;
    inst_raddr = 12'($urandom);
    @(negedge clk);
    check("accept", {req_ready, inst_ready, busy, csr_we, redirect_valid},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0});

    while (exp_q.size() > 0) begin
      next_cycle();
      req_valid  = 1'($urandom);
      req_mret   = 1'($urandom);
      req_pc     = $urandom;
      req_cause  = $urandom;
      inst_raddr = 12'($urandom);
      if (!hold_we) begin
        inst_we    = 1'($urandom);
        inst_waddr = 12'($urandom);
        inst_wdata = $urandom;
      end
      @(negedge clk);
      check("busy", {busy, req_ready, inst_ready}, {1'b1, 1'b0, 1'b0});
      check(mret ? "mret_seq" : "trap_seq", obs_trace(), exp_q.pop_front());
    end
    next_cycle();
    req_valid = 1'b0;
    if (!hold_we) inst_we = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [XLEN-1:0] pc_r, cause_r;
    idle_inputs();

    // Reset state, including the pass-through write path during reset.
    #2;
    check("rst_state", {busy, req_ready, inst_ready, redirect_valid, csr_we},
          {1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
    inst_we = 1'b1; inst_waddr = 12'h340; inst_wdata = 32'hA5A5_0001;
    #1;
    check("rst_pass_we", {csr_we, csr_waddr, csr_wdata}, {1'b1, 12'h340, 32'hA5A5_0001});
    inst_we = 1'b0;
    @(negedge clk); rst = 1'b0;
    next_cycle();

    // Directed trap entry.
    csr_write(CSR_MTVEC, 32'h8000_0103);
    csr_write(CSR_MSTATUS, 32'h0000_0008);
    csr_write(CSR_MEPC, 32'h0);
    csr_write(CSR_MCAUSE, 32'h0);
    run_req(1'b0, 32'h8000_0040, CAUSE_ECALL_M, 1'b0, 12'h0, '0);
    inst_raddr = CSR_MSTATUS;
    @(negedge clk);
    check("trap_mstatus_abs", {busy, csr_rdata}, {1'b0, 32'h0000_1880});
    inst_raddr = CSR_MEPC;
    #1;
    check("trap_mepc_abs", csr_rdata, 32'h8000_0040);

    // Directed mret.
    next_cycle();
    csr_write(CSR_MEPC, 32'h8000_0044);
    run_req(1'b1, $urandom, $urandom, 1'b0, 12'h0, '0);
    csr_read_check("mret_mstatus", CSR_MSTATUS);
    inst_raddr = CSR_MSTATUS;
    @(negedge clk);
    check("mret_mstatus_abs", csr_rdata, 32'h0000_1888);
    next_cycle();

    // Arbitration: instruction write collides with a trap request and is held.
    run_req(1'b0, 32'h8000_0100, CAUSE_ILLEGAL_INSN, 1'b1, CSR_MTVEC, 32'h0000_1234);
    @(negedge clk);
    check("arb_grant", {busy, inst_ready, csr_we, csr_waddr, csr_wdata},
          {1'b0, 1'b1, 1'b1, CSR_MTVEC, 32'h0000_1234});
    next_cycle();
    inst_we = 1'b0;
    m_mtvec = 32'h0000_1234;
    csr_read_check("arb_mtvec", CSR_MTVEC);

    // Back-to-back trap then mret; busy is low only on the mret accept cycle.
    csr_write(CSR_MSTATUS, 32'h0000_0008);
    run_req(1'b0, 32'h8000_0200, CAUSE_ECALL_M, 1'b0, 12'h0, '0);
    run_req(1'b1, $urandom, $urandom, 1'b0, 12'h0, '0);
    inst_raddr = CSR_MSTATUS;
    @(negedge clk);
    check("b2b_mie", csr_rdata[3], 1'b1);
    next_cycle();

    // Reset in the middle of a trap, while in T_CAUSE.
    csr_write(CSR_MCAUSE, 32'h0000_0077);
    csr_write(CSR_MSTATUS, 32'h0000_0008);
    req_valid = 1'b1; req_mret = 1'b0; req_pc = 32'h8000_0300; req_cause = CAUSE_ECALL_M;
    next_cycle();
    req_valid = 1'b0;
    @(negedge clk);
    check("rst_seq_epc", obs_trace(), ent(1'b1, CSR_MEPC, 32'h8000_0300, 1'b0, '0));
    m_mepc = 32'h8000_0300;
    next_cycle();
    @(negedge clk);
    check("rst_seq_cause", obs_trace(), ent(1'b1, CSR_MCAUSE, CAUSE_ECALL_M, 1'b0, '0));
    #2 rst = 1'b1;
    #1;
    check("rst_async", {busy, req_ready, redirect_valid, csr_we}, {1'b0, 1'b1, 1'b0, 1'b0});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_hold", {busy, redirect_valid, csr_we}, {1'b0, 1'b0, 1'b0});
    end
    rst = 1'b0;
    next_cycle();
    @(negedge clk);
    check("rst_release", {busy, req_ready, redirect_valid}, {1'b0, 1'b1, 1'b0});
    next_cycle();
    csr_read_check("rst_mcause", CSR_MCAUSE);
    csr_read_check("rst_mstatus", CSR_MSTATUS);
    csr_read_check("rst_mepc", CSR_MEPC);

    // Pass-through while idle.
    inst_raddr = 12'h305; inst_we = 1'b0;
    #1;
    check("pass_raddr", {inst_ready, csr_raddr, csr_we}, {1'b1, 12'h305, 1'b0});
    inst_we = 1'b1; inst_waddr = 12'h340; inst_wdata = 32'h1357_9BDF;
    #1;
    check("pass_we", {csr_we, csr_waddr, csr_wdata}, {1'b1, 12'h340, 32'h1357_9BDF});
    next_cycle();
    inst_we = 1'b0;

    // Randomized transactions against the shadow model.
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 1) == 1) csr_write(CSR_MSTATUS, $urandom);
      if ($urandom_range(0, 2) == 0) csr_write(CSR_MTVEC, $urandom);
      if ($urandom_range(0, 2) == 0) csr_write(CSR_MEPC, $urandom);
      pc_r = $urandom;
      cause_r = ($urandom_range(0, 1) == 1) ? CAUSE_ECALL_M : $urandom;
      run_req(1'($urandom), pc_r, cause_r, 1'b0, 12'h0, '0);
      if ($urandom_range(0, 3) == 0) csr_read_check("rnd_mstatus", CSR_MSTATUS);
    end
    csr_read_check("end_mstatus", CSR_MSTATUS);
    csr_read_check("end_mepc", CSR_MEPC);
    csr_read_check("end_mcause", CSR_MCAUSE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
